// File: rtl/secam_line_sequencer.sv
// rtl/secam_line_sequencer.sv - SECAM chroma line/frame sequencer; optional SECAM_FRAME_ALTERNATE_EN frame polarity alternation
`timescale 1ns/1ps
module secam_line_sequencer #(
  parameter int CARRIER_ON        = 300,
  parameter int ACTIVE_START      = 400,
  parameter int ACTIVE_END        = 2900,
  parameter int CARRIER_OFF       = 2950,
  parameter int ACTIVE_LINE_FIRST = 23,
  parameter int ACTIVE_LINE_LAST  = 310
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        newframe,
  input  logic        newline,
  output logic        even_line,
  output logic        enabled,
  output logic        modulate,
  output logic [9:0]  line_count,
  output logic [11:0] h_count
);

  if (!((CARRIER_ON >= 0) && (CARRIER_ON < ACTIVE_START) && (ACTIVE_START < ACTIVE_END) &&
        (ACTIVE_END < CARRIER_OFF) && (CARRIER_OFF <= 4095) && (ACTIVE_LINE_FIRST >= 0) &&
        (ACTIVE_LINE_FIRST <= ACTIVE_LINE_LAST) && (ACTIVE_LINE_LAST <= 1023))) begin : g_param_check
    $fatal(1, "secam_line_sequencer: illegal timing parameters");
  end

  localparam logic [11:0] LP_CARRIER_ON   = 12'(CARRIER_ON);
  localparam logic [11:0] LP_ACTIVE_START = 12'(ACTIVE_START);
  localparam logic [11:0] LP_ACTIVE_END   = 12'(ACTIVE_END);
  localparam logic [11:0] LP_CARRIER_OFF  = 12'(CARRIER_OFF);
  localparam logic [9:0]  LP_LINE_FIRST   = 10'(ACTIVE_LINE_FIRST);
  localparam logic [9:0]  LP_LINE_LAST    = 10'(ACTIVE_LINE_LAST);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_WAIT,
    ST_REF_PRE,
    ST_ACTIVE,
    ST_REF_POST
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [11:0] r_h_count;
  logic [9:0]  r_line_count;
  logic        r_even_line;
  logic        r_enabled;
  logic        r_modulate;
  logic        w_line_start;
  logic [9:0]  w_line_next;
  logic        w_line_active;
  logic        w_frame_polarity;
  logic        w_enabled_next;
  logic        w_modulate_next;

  assign w_line_start  = newline | newframe;
  assign w_line_next   = newframe ? 10'd0 :
                         (newline && (r_line_count != 10'h3FF)) ? r_line_count + 10'd1 :
                         r_line_count;
  assign w_line_active = (w_line_next >= LP_LINE_FIRST) && (w_line_next <= LP_LINE_LAST);

`ifdef SECAM_FRAME_ALTERNATE_EN
  logic r_frame_flag;

  // Frame polarity flag: each frame start consumes the current polarity and flips it for the next frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_flag <= 1'b1;
    end else if (newframe) begin
      r_frame_flag <= ~r_frame_flag;
    end
  end

  assign w_frame_polarity = r_frame_flag;
`else
  assign w_frame_polarity = 1'b1;
`endif

  // Horizontal position, line number and Db/Dr alternation tracking from the timing strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h_count    <= 12'd0;
      r_line_count <= 10'd0;
      r_even_line  <= 1'b1;
    end else begin
      if (w_line_start) begin
        r_h_count <= 12'd0;
      end else if (r_h_count != 12'hFFF) begin
        r_h_count <= r_h_count + 12'd1;
      end
      r_line_count <= w_line_next;
      if (newframe) begin
        r_even_line <= w_frame_polarity;
      end else if (newline) begin
        r_even_line <= ~r_even_line;
      end
    end
  end

  // Carrier state machine: a line start always restarts the line, otherwise step on h-position thresholds
  always_comb begin
    w_state_next = r_state;
    if (w_line_start) begin
      w_state_next = w_line_active ? ST_WAIT : ST_OFF;
    end else begin
      case (r_state)
        ST_WAIT:     if (r_h_count == LP_CARRIER_ON)   w_state_next = ST_REF_PRE;
        ST_REF_PRE:  if (r_h_count == LP_ACTIVE_START) w_state_next = ST_ACTIVE;
        ST_ACTIVE:   if (r_h_count == LP_ACTIVE_END)   w_state_next = ST_REF_POST;
        ST_REF_POST: if (r_h_count == LP_CARRIER_OFF)  w_state_next = ST_OFF;
        default:     w_state_next = ST_OFF;
      endcase
    end
    w_enabled_next  = (w_state_next == ST_REF_PRE) || (w_state_next == ST_ACTIVE) ||
                      (w_state_next == ST_REF_POST);
    w_modulate_next = (w_state_next == ST_ACTIVE);
  end

  // State register with registered encoder control decode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_OFF;
      r_enabled  <= 1'b0;
      r_modulate <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_enabled  <= w_enabled_next;
      r_modulate <= w_modulate_next;
    end
  end

  assign even_line  = r_even_line;
  assign enabled    = r_enabled;
  assign modulate   = r_modulate;
  assign line_count = r_line_count;
  assign h_count    = r_h_count;

endmodule

// File: tb/tb_secam_line_sequencer.sv
// tb/tb_secam_line_sequencer.sv - randomized self-checking bench for secam_line_sequencer
`timescale 1ns/1ps
module tb_secam_line_sequencer;
  localparam int CARRIER_ON   = 300;
  localparam int ACTIVE_START = 400;
  localparam int ACTIVE_END   = 2900;
  localparam int CARRIER_OFF  = 2950;
  localparam int LINE_FIRST   = 23;
  localparam int LINE_LAST    = 310;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        newframe = 1'b0;
  logic        newline = 1'b0;
  logic        even_line;
  logic        enabled;
  logic        modulate;
  logic [9:0]  line_count;
  logic [11:0] h_count;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: position since last strobe, line number, polarity, and whether this line carries chroma
  int m_pos = 0;
  int m_line = 0;
  bit m_even = 1'b1;
  bit m_lineok = 1'b0;
`ifdef SECAM_FRAME_ALTERNATE_EN
  bit m_flag = 1'b1;
`endif

  secam_line_sequencer #(
    .CARRIER_ON(CARRIER_ON), .ACTIVE_START(ACTIVE_START), .ACTIVE_END(ACTIVE_END),
    .CARRIER_OFF(CARRIER_OFF), .ACTIVE_LINE_FIRST(LINE_FIRST), .ACTIVE_LINE_LAST(LINE_LAST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .newframe(newframe), .newline(newline),
    .even_line(even_line), .enabled(enabled), .modulate(modulate),
    .line_count(line_count), .h_count(h_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pos = 0; m_line = 0; m_even = 1'b1; m_lineok = 1'b0;
`ifdef SECAM_FRAME_ALTERNATE_EN
      m_flag = 1'b1;
`endif
    end else begin
      if (newframe) begin
        m_line = 0;
`ifdef SECAM_FRAME_ALTERNATE_EN
        m_even = m_flag;
        m_flag = !m_flag;
`else
        m_even = 1'b1;
`endif
      end else if (newline) begin
        if (m_line < 1023) m_line++;
        m_even = !m_even;
      end
      if (newframe || newline) begin
        m_pos = 0;
        m_lineok = (m_line >= LINE_FIRST) && (m_line <= LINE_LAST);
      end else begin
        m_pos++;
      end
    end
  end

  always @(negedge clk) begin : compare
    int eh;
    int ee;
    int em;
    eh = (m_pos > 4095) ? 4095 : m_pos;
    ee = (m_lineok && m_pos > CARRIER_ON && m_pos <= CARRIER_OFF) ? 1 : 0;
    em = (m_lineok && m_pos > ACTIVE_START && m_pos <= ACTIVE_END) ? 1 : 0;
    check("h_count", int'(h_count), eh);
    check("line_count", int'(line_count), m_line);
    check("even_line", int'(even_line), int'(m_even));
    check("enabled", int'(enabled), ee);
    check("modulate", int'(modulate), em);
    check("mod_without_en", int'(modulate && !enabled), 0);
  end

  task automatic step(input bit nf, input bit nl, input bit rs);
    newframe = nf; newline = nl; rst_n = rs;
    @(negedge clk);
    newframe = 1'b0; newline = 1'b0; rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b1);
  endtask

  // Frame start then target-1 short lines; caller issues the final newline
  task automatic to_line(input int target);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 1; i < target; i++) begin
      step(1'b0, 1'b1, 1'b1);
      run($urandom_range(0, 3));
    end
  endtask

  initial begin : stim
    int en_cnt;
    int mod_cnt;
    int len;
    bit ev;

    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("rst_en", int'(enabled), 0);
    check("rst_mod", int'(modulate), 0);
    check("rst_even", int'(even_line), 1);
    check("rst_line", int'(line_count), 0);
    check("rst_h", int'(h_count), 0);

    to_line(23);
    step(1'b0, 1'b1, 1'b1);
    check("s2_line", int'(line_count), 23);
    check("s2_en_c0", int'(enabled), 0);
    en_cnt = 0; mod_cnt = 0;
    for (int k = 1; k <= 3000; k++) begin
      step(1'b0, 1'b0, 1'b1);
      en_cnt += int'(enabled);
      mod_cnt += int'(modulate);
      if (k == 300)  check("s2_en_300", int'(enabled), 0);
      if (k == 301)  check("s2_en_301", int'(enabled), 1);
      if (k == 2950) check("s2_en_2950", int'(enabled), 1);
      if (k == 2951) check("s2_en_2951", int'(enabled), 0);
      if (k == 400)  check("s2_mod_400", int'(modulate), 0);
      if (k == 401)  check("s2_mod_401", int'(modulate), 1);
      if (k == 2900) check("s2_mod_2900", int'(modulate), 1);
      if (k == 2901) check("s2_mod_2901", int'(modulate), 0);
    end
    check("s2_en_cycles", en_cnt, 2650);
    check("s2_mod_cycles", mod_cnt, 2500);

    to_line(5);
    ev = even_line;
    step(1'b0, 1'b1, 1'b1);
    check("s3_line", int'(line_count), 5);
    check("s3_even_toggle", int'(even_line), int'(!ev));
    en_cnt = 0;
    for (int k = 1; k <= 3000; k++) begin
      step(1'b0, 1'b0, 1'b1);
      en_cnt += int'(enabled);
    end
    check("s3_en_cycles", en_cnt, 0);

    to_line(23);
    step(1'b0, 1'b1, 1'b1);
    run(1000);
    check("s5_mod_before", int'(modulate), 1);
    step(1'b0, 1'b1, 1'b1);
    check("s5_en_drop", int'(enabled), 0);
    check("s5_mod_drop", int'(modulate), 0);
    check("s5_line_inc", int'(line_count), 24);
    check("s5_h_zero", int'(h_count), 0);
    run(3000);

    to_line(23);
    step(1'b0, 1'b1, 1'b1);
    run(1000);
    check("s6_en_before", int'(enabled), 1);
    step(1'b0, 1'b0, 1'b0);
    check("s6_en_rst", int'(enabled), 0);
    check("s6_mod_rst", int'(modulate), 0);
    check("s6_even_rst", int'(even_line), 1);
    check("s6_line_rst", int'(line_count), 0);
    check("s6_h_rst", int'(h_count), 0);
    en_cnt = 0;
    for (int k = 1; k <= 5000; k++) begin
      step(1'b0, 1'b0, 1'b1);
      en_cnt += int'(enabled);
    end
    check("s6_no_carrier", en_cnt, 0);
    check("s7_h_sat", int'(h_count), 4095);
    check("s7_en_off", int'(enabled), 0);

    step(1'b0, 1'b0, 1'b0);
    for (int f = 0; f < 4; f++) begin
      step(1'b1, 1'b1, 1'b1);
      check("s4_line", int'(line_count), 0);
      check("s4_h", int'(h_count), 0);
`ifdef SECAM_FRAME_ALTERNATE_EN
      check("s4_even", int'(even_line), (f % 2 == 0) ? 1 : 0);
`else
      check("s4_even", int'(even_line), 1);
`endif
      run(2);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      run(1);
    end

    for (int fr = 0; fr < 2; fr++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
      run($urandom_range(0, 5));
      for (int ln = 1; ln <= 26; ln++) begin
        step(1'b0, 1'b1, 1'b1);
        len = (ln >= 21) ? $urandom_range(200, 3300) : $urandom_range(0, 20);
        run(len);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
